cpu_sequential: RTL and testbench

CPU_SEQUENTIAL -- requirements
Module: cpu_sequential

---
 rtl/cpu_sequential.sv | 232 +++++++++++++++++++++++
 tb/tb_cpu_sequential.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequential.sv
// Single-cycle RV64 subset core (add/sub/and/or/addi/ld/sd/beq).
// Ports:
//   clk   - system clock, all state updates on its rising edge
//   reset - asynchronous active-high reset (pc and registers to zero)
// Internal state is visible only through hierarchy: imem.memory, dmem.memory,
// reg_file.registers and the named datapath nets in cpu_sequential.

// Instruction memory: word-addressed, combinational read, zero beyond range.
module cpu_imem #(
  parameter int unsigned WORDS = 256
) (
  input  logic [61:0] word_idx,
  output logic [31:0] rdata
);
  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] memory [0:WORDS-1] = '{default: '0};

  always_comb begin
    rdata = '0;
    if (word_idx < 62'(WORDS)) rdata = memory[word_idx[AW-1:0]];
  end
endmodule

// Data memory: 64-bit words, combinational read, write on rising edge.
// Contents are never cleared by reset; writes are suppressed while reset is high.
module cpu_dmem #(
  parameter int unsigned WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [60:0] word_idx,
  input  logic        re,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] rdata
);
  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [63:0] memory [0:WORDS-1] = '{default: '0};
  logic        in_range;

  assign in_range = (word_idx < 61'(WORDS));

  always_comb begin
    rdata = '0;
    if (re && in_range) rdata = memory[word_idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset && we && in_range) memory[word_idx[AW-1:0]] <= wdata;
  end
endmodule

// 32 x 64-bit register file; x0 is hardwired to zero.
module cpu_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] rdata1,
  output logic [63:0] rdata2
);
  logic [63:0] registers [0:31];

  assign rdata1 = (rs1_addr == 5'd0) ? 64'd0 : registers[rs1_addr];
  assign rdata2 = (rs2_addr == 5'd0) ? 64'd0 : registers[rs2_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      registers[rd_addr] <= wdata;
    end
  end
endmodule

module cpu_sequential #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;

  logic [63:0] pc_current, pc_current_d, pc_current_q;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, branch, mem_read, mem_to_reg, mem_write, alu_src;
  logic        halt;
  alu_op_e     alu_op;
  logic [63:0] imm, imm_i, imm_s, imm_b;
  logic [63:0] reg_read_data1, reg_read_data2, alu_b, alu_result;
  logic [63:0] mem_read_data, reg_write_data;

  assign pc_current = pc_current_q;

  cpu_imem #(.WORDS(IMEM_WORDS)) imem (
    .word_idx (pc_current[63:2]),
    .rdata    (instruction)
  );

  // Field extraction and immediate sign extension
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign rd     = instruction[11:7];
  assign halt   = (instruction == 32'h0000_0000);

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

  // Main decoder; anything unrecognised (including halt) leaves every control low
  always_comb begin
    reg_write  = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    imm        = imm_i;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin
            reg_write = 1'b1;
            alu_op    = instruction[30] ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            reg_write = 1'b1;
            alu_op    = ALU_AND;
          end
          3'b110: begin
            reg_write = 1'b1;
            alu_op    = ALU_OR;
          end
          default: ;
        endcase
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          alu_src   = 1'b1;
          reg_write = 1'b1;
        end
      end
      OP_LD: begin
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      OP_SD: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm       = imm_s;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  cpu_reg_file reg_file (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .we       (reg_write),
    .wdata    (reg_write_data),
    .rdata1   (reg_read_data1),
    .rdata2   (reg_read_data2)
  );

  // ALU, 64-bit wraparound
  assign alu_b = alu_src ? imm : reg_read_data2;

  always_comb begin
    alu_result = reg_read_data1 + alu_b;
    case (alu_op)
      ALU_SUB: alu_result = reg_read_data1 - alu_b;
      ALU_AND: alu_result = reg_read_data1 & alu_b;
      ALU_OR:  alu_result = reg_read_data1 | alu_b;
      default: alu_result = reg_read_data1 + alu_b;
    endcase
  end

  cpu_dmem #(.WORDS(DMEM_WORDS)) dmem (
    .clk      (clk),
    .reset    (reset),
    .word_idx (alu_result[63:3]),
    .re       (mem_read),
    .we       (mem_write),
    .wdata    (reg_read_data2),
    .rdata    (mem_read_data)
  );

  assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;

  // Next pc: hold on halt, take beq when operands are equal, else fall through
  always_comb begin
    pc_current_d = pc_current_q + 64'd4;
    if (halt) begin
      pc_current_d = pc_current_q;
    end else if (branch && (alu_result == 64'd0)) begin
      pc_current_d = pc_current_q + imm_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_current_q <= '0;
    else       pc_current_q <= pc_current_d;
  end
endmodule

// File: tb/tb_cpu_sequential.sv
// Directed self-checking bench for cpu_sequential: arithmetic/logic,
// load/store, branch over skipped code, x0 handling, unsupported opcodes,
// out-of-range imem/dmem, factorial program with mid-run reset.
module tb_cpu_sequential;
  logic clk;
  logic reset;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_sequential #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'b000, 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int rs1, input int rs2, input int imm);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  localparam int OPI = 7'b0010011;
  localparam int OPL = 7'b0000011;

  // Hold reset, wipe imem; caller then writes the program and calls release_reset
  task automatic begin_load();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.imem.memory[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  task automatic wait_pc(input string tag, input logic [63:0] target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (dut.pc_current == target) break;
    end
    check(tag, dut.pc_current, target);
  endtask

  logic [63:0] acc;

  initial begin
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_pc", dut.pc_current, 64'd0);
    check("reset_x1", dut.reg_file.registers[1], 64'd0);
    check("reset_dmem3", dut.dmem.memory[3], 64'd0);

    // Arithmetic / logic
    begin_load();
    dut.imem.memory[0] = enc_i(OPI, 5, 0, 7);
    dut.imem.memory[1] = enc_i(OPI, 6, 0, -3);
    dut.imem.memory[2] = enc_r(7'h20, 6, 5, 0, 7);
    dut.imem.memory[3] = enc_r(0, 6, 5, 7, 8);
    dut.imem.memory[4] = enc_r(0, 6, 5, 6, 9);
    release_reset();
    run(8);
    check("alu_x5", dut.reg_file.registers[5], 64'd7);
    check("alu_x6", dut.reg_file.registers[6], 64'hFFFF_FFFF_FFFF_FFFD);
    check("alu_sub_x7", dut.reg_file.registers[7], 64'd10);
    check("alu_and_x8", dut.reg_file.registers[8], 64'd5);
    check("alu_or_x9", dut.reg_file.registers[9], 64'hFFFF_FFFF_FFFF_FFFF);
    check("alu_halt_pc", dut.pc_current, 64'h14);
    run(3);
    check("alu_halt_hold", dut.pc_current, 64'h14);

    // Store then load through dmem word 3
    begin_load();
    dut.imem.memory[0] = enc_i(OPI, 1, 0, 16);
    dut.imem.memory[1] = enc_i(OPI, 2, 0, -5);
    dut.imem.memory[2] = enc_s(2, 1, 8);
    dut.imem.memory[3] = enc_i(OPL, 3, 1, 8);
    release_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("mem_write_c%0d", k), 64'(dut.mem_write), (k == 2) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    run(2);
    check("sd_dmem3", dut.dmem.memory[3], 64'hFFFF_FFFF_FFFF_FFFB);
    check("ld_x3", dut.reg_file.registers[3], 64'hFFFF_FFFF_FFFF_FFFB);

    // x0 write discard, taken beq, unsupported R funct3 and opcode as no-ops
    begin_load();
    dut.imem.memory[0] = enc_i(OPI, 0, 0, 5);
    dut.imem.memory[1] = enc_b(0, 0, 8);
    dut.imem.memory[2] = enc_i(OPI, 20, 0, 99);
    dut.imem.memory[3] = enc_i(OPI, 21, 0, 1);
    dut.imem.memory[4] = enc_r(0, 21, 21, 1, 22);
    dut.imem.memory[5] = {20'h00000, 5'd23, 7'h7F};
    dut.imem.memory[6] = enc_i(OPI, 24, 0, 3);
    release_reset();
    @(negedge clk);
    check("beq_pc_before", dut.pc_current, 64'h4);
    check("beq_branch_ctl", 64'(dut.branch), 64'd1);
    @(negedge clk);
    check("beq_target", dut.pc_current, 64'hC);
    run(6);
    check("x0_zero", dut.reg_file.registers[0], 64'd0);
    check("skipped_x20", dut.reg_file.registers[20], 64'd0);
    check("after_x21", dut.reg_file.registers[21], 64'd1);
    check("bad_funct3_x22", dut.reg_file.registers[22], 64'd0);
    check("bad_opcode_x23", dut.reg_file.registers[23], 64'd0);
    check("after_nop_x24", dut.reg_file.registers[24], 64'd3);
    check("nop_halt_pc", dut.pc_current, 64'h1C);

    // Out-of-range dmem store ignored; branch past imem end reads zero (halt)
    begin_load();
    dut.imem.memory[0] = enc_i(OPI, 1, 0, 512);
    dut.imem.memory[1] = enc_i(OPI, 2, 0, 77);
    dut.imem.memory[2] = enc_s(2, 1, 0);
    dut.imem.memory[3] = enc_b(0, 0, 244);
    release_reset();
    run(8);
    check("oor_pc", dut.pc_current, 64'h100);
    check("oor_dmem0", dut.dmem.memory[0], 64'd0);
    check("oor_dmem3", dut.dmem.memory[3], 64'hFFFF_FFFF_FFFF_FFFB);

    // Factorial of 20 by repeated addition, halt at word 13 (pc 0x34)
    begin_load();
    dut.imem.memory[0]  = enc_i(OPI, 10, 0, 20);
    dut.imem.memory[1]  = enc_i(OPI, 11, 0, 1);
    dut.imem.memory[2]  = enc_i(OPI, 14, 0, 0);
    dut.imem.memory[3]  = enc_b(10, 0, 40);
    dut.imem.memory[4]  = enc_i(OPI, 14, 14, 1);
    dut.imem.memory[5]  = enc_r(0, 0, 11, 0, 12);
    dut.imem.memory[6]  = enc_i(OPI, 13, 14, -1);
    dut.imem.memory[7]  = enc_b(13, 0, 16);
    dut.imem.memory[8]  = enc_r(0, 12, 11, 0, 11);
    dut.imem.memory[9]  = enc_i(OPI, 13, 13, -1);
    dut.imem.memory[10] = enc_b(0, 0, -12);
    dut.imem.memory[11] = enc_i(OPI, 10, 10, -1);
    dut.imem.memory[12] = enc_b(0, 0, -36);
    release_reset();
    run(300);
    check("midrun_x10_nonzero", 64'(dut.reg_file.registers[10] != 64'd0), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pc", dut.pc_current, 64'd0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | dut.reg_file.registers[i];
    check("async_rst_regs", acc, 64'd0);
    check("async_rst_dmem3", dut.dmem.memory[3], 64'hFFFF_FFFF_FFFF_FFFB);
    run(2);
    check("rst_hold_pc", dut.pc_current, 64'd0);
    release_reset();
    wait_pc("fact_halt_pc", 64'h34, 3000);
    check("fact_x10", dut.reg_file.registers[10], 64'd0);
    check("fact_x11", dut.reg_file.registers[11], 64'h21C3_677C_82B4_0000);
    check("fact_x12", dut.reg_file.registers[12], 64'd121645100408832000);
    check("fact_x13", dut.reg_file.registers[13], 64'd0);
    run(4);
    check("fact_hold_pc", dut.pc_current, 64'h34);
    check("fact_dmem3", dut.dmem.memory[3], 64'hFFFF_FFFF_FFFF_FFFB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
